fetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of the combinational instruction memory. It owns the program counter, drives the memory's word-aligned fetch address and captures the returned word with its PC into a small FIFO. Decode drains the FIFO through a valid/ready handshake. Control redirects from branches and jumps flush the FIFO and restart fetch at a new PC.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, fetches from a combinational instruction
// memory and queues {pc, instr} pairs for decode behind a valid/ready handshake.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_WIDTH-1:0]   instr_addr,
  input  logic [DATA_WIDTH-1:0]   instr,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instr,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q,    state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]       count_q,    count_d;
  logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem_d    [DEPTH];
  logic [DATA_WIDTH-1:0]  instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  instr_mem_d [DEPTH];

  logic push;
  logic pop;
  logic redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign instr_addr = fetch_pc_q;
  assign out_valid  = (count_q != '0);
  assign out_instr  = instr_mem_q[rd_ptr_q];
  assign out_pc     = pc_mem_q[rd_ptr_q];
  assign count      = count_q;

  assign pop  = out_valid && out_ready;
  assign push = (state_q == RUN) && !redirect_valid && ((count_q < FULL) || pop);

  always_comb begin
    state_d     = RUN;
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    if (redirect_valid) begin
      // Storage is left intact; dropping pointers and count discards the entries.
      fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = instr;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        fetch_pc_d            = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked by a
// queue-level reference model feeding a scoreboard drained by a separate monitor.
module tb_fetch_queue;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] count;

  fetch_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RESET_PC),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_addr     (instr_addr),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word = 0x100 + address.
  assign instr = instr_addr + 32'h100;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } entry_t;

  entry_t        exp_q[$];
  logic [AW-1:0] m_pc   = RESET_PC;
  bit            m_boot = 1'b1;
  bit            mon_en = 1'b0;
  int unsigned   total  = 0;
  int unsigned   bad    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: just after each falling edge the DUT state reflects the last rising
  // edge and the inputs for the next one are settled.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("count", 64'(count), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("instr_addr", 64'(instr_addr), 64'(m_pc));
        if (out_valid && out_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_pc", 64'(out_pc), 64'(e.pc));
          check("out_instr", 64'(out_instr), 64'(e.ins));
        end
      end
    end
  end

  // Drive one cycle of inputs and advance the reference model across the next edge.
  task automatic step(input bit rdy, input bit rv, input logic [AW-1:0] rpc);
    bit pop;
    bit push;
    @(negedge clk);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pop  = rdy && (exp_q.size() != 0);
    push = !m_boot && !rv && ((exp_q.size() < DEPTH) || pop);
    #3;
    if (rv) begin
      exp_q.delete();
      m_pc = {rpc[AW-1:2], 2'b00};
    end else if (push) begin
      exp_q.push_back('{pc: m_pc, ins: m_pc + 32'h100});
      m_pc = m_pc + 32'd4;
    end
    m_boot = 1'b0;
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc   = RESET_PC;
    m_boot = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    #3;
    m_boot = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_addr"}, 64'(instr_addr), 64'(RESET_PC));
    check({tag, "_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_instr"}, 64'(out_instr), 64'd0);
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    release_reset();

    // Streaming with decode always ready.
    step(1, 0, '0);
    peek();
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_pc", 64'(out_pc), 64'(RESET_PC));
    repeat (8) step(1, 0, '0);

    // Fill, then reset asynchronously between edges.
    repeat (3) step(0, 0, '0);
    mon_en = 1'b0;
    check("pre_rst_count", 64'(count), 64'd2);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_state("async");
    repeat (2) @(posedge clk);
    release_reset();

    // Back-pressure from boot.
    repeat (10) step(0, 0, '0);
    peek();
    check("stall_addr", 64'(instr_addr), 64'h8);
    check("stall_pc", 64'(out_pc), 64'h0);
    check("stall_count", 64'(count), 64'd2);
    repeat (4) step(1, 0, '0);

    // Redirect while full and stalled.
    repeat (3) step(0, 0, '0);
    step(0, 1, 32'h203);
    peek();
    check("redir_count", 64'(count), 64'd0);
    check("redir_valid", 64'(out_valid), 64'd0);
    check("redir_addr", 64'(instr_addr), 64'h200);
    step(0, 0, '0);
    peek();
    check("redir_pc", 64'(out_pc), 64'h200);

    // Redirect coincident with a pop handshake.
    repeat (2) step(0, 0, '0);
    step(1, 1, 32'h400);
    step(1, 0, '0);
    peek();
    check("redir_pop_pc", 64'(out_pc), 64'h400);
    repeat (3) step(1, 0, '0);

    // Address wrap.
    step(1, 1, 32'hFFFF_FFF8);
    repeat (5) step(1, 0, '0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, ($urandom % 12) == 0, $urandom);
      if ($urandom % 16 == 0) begin
        step(1, 1, 32'hFFFF_FFF0 | ($urandom % 16));
      end
    end
    repeat (3) step(1, 0, '0);

    @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
